// File: rtl/input_debounce.sv
// Synchroniser plus stability-counter debouncer; dout feeds the edge detector's level input.
// Defining DEBOUNCE_GLITCH_CNT_EN adds glitch_clr/glitch_cnt, a saturating rejected-glitch counter.
module input_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   CNT_W           = 16,
    parameter int   DEBOUNCE_CYCLES = 1000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din_raw,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    input  logic       glitch_clr,
    output logic [7:0] glitch_cnt,
`endif
    output logic       dout,
    output logic       busy
);

    typedef enum logic {
        STABLE  = 1'b0,
        CONFIRM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dout_q, dout_d;

    // din_raw is only ever touched by the first flop of this chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s != dout_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        dout_d = s;
                    end else begin
                        cnt_d   = CNT_ONE;
                        state_d = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (s == dout_q) begin
                    cnt_d   = '0;
                    state_d = STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    dout_d  = s;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = STABLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            dout_q  <= RESET_LEVEL;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;
    assign busy = (state_q == CONFIRM);

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       glitch;
    logic [7:0] glitch_q;

    // A bounce-back out of CONFIRM is one rejected glitch; clear beats a same-cycle glitch
    assign glitch = (state_q == CONFIRM) && (s == dout_q);

    always_ff @(posedge clk) begin
        if (!rst_n || glitch_clr) begin
            glitch_q <= 8'd0;
        end else if (glitch && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: three instances (defaults, 1-cycle, 8-cycle debounce),
// a vector table, hand-written corner sequences and a random run against a run-length reference model.
module tb_input_debounce;

    localparam int SYNC = 2;
    localparam int D8   = 8;

    typedef struct packed {
        logic din1;
        logic din8;
        logic exp_dout1;
        logic exp_busy1;
        logic exp_dout8;
        logic exp_busy8;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic din_def, din1, din8;
    logic glitch_clr;
    logic dout_def, busy_def, dout1, busy1, dout8, busy8;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] gcnt_def, gcnt1, gcnt8;
`endif

    int   checks   = 0;
    int   errors   = 0;
    logic model_en = 1'b0;

    always #5 clk = ~clk;

    input_debounce dut_def (
        .clk(clk), .rst_n(rst_n), .din_raw(din_def),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .glitch_clr(glitch_clr), .glitch_cnt(gcnt_def),
`endif
        .dout(dout_def), .busy(busy_def)
    );

    input_debounce #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .din_raw(din1),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .glitch_clr(glitch_clr), .glitch_cnt(gcnt1),
`endif
        .dout(dout1), .busy(busy1)
    );

    input_debounce #(.DEBOUNCE_CYCLES(D8)) dut8 (
        .clk(clk), .rst_n(rst_n), .din_raw(din8),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .glitch_clr(glitch_clr), .glitch_cnt(gcnt8),
`endif
        .dout(dout8), .busy(busy8)
    );

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic d_def, input logic d_1, input logic d_8);
        din_def = d_def;
        din1    = d_1;
        din8    = d_8;
    endtask

    // Reference for dut8: s is din delayed by SYNC samples; dout flips once s has differed
    // from it for D8 samples in a row, and any return before that is a rejected glitch.
    logic m_pipe[$];
    logic m_dout   = 1'b0;
    int   m_run    = 0;
    int   m_glitch = 0;

    task automatic modelStep();
        logic s;
        logic bounce;
        if (!rst_n) begin
            m_pipe = {};
            for (int i = 0; i < SYNC; i++) m_pipe.push_back(1'b0);
            m_dout   = 1'b0;
            m_run    = 0;
            m_glitch = 0;
        end else begin
            s = m_pipe.pop_front();
            m_pipe.push_back(din8);
            bounce = 1'b0;
            if (s != m_dout) begin
                m_run++;
                if (m_run >= D8) begin
                    m_dout = s;
                    m_run  = 0;
                end
            end else begin
                bounce = (m_run > 0);
                m_run  = 0;
            end
            if (glitch_clr) m_glitch = 0;
            else if (bounce && m_glitch < 255) m_glitch++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    initial forever begin
        @(negedge clk);
        if (model_en) begin
            checkOutput("model_dout8", dout8, m_dout);
            checkOutput("model_busy8", busy8, (m_run > 0));
            checkOutput("busy1_never", busy1, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
            checkOutput("model_glitch8", gcnt8, m_glitch[7:0]);
`endif
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Two-sample pulse on s; the bounce-back lands on the fifth edge, where clr_last is applied
    task automatic glitchPulse(input logic clr_last);
        din8 = 1'b1;
        repeat (2) @(negedge clk);
        din8 = 1'b0;
        repeat (2) @(negedge clk);
        glitch_clr = clr_last;
        @(negedge clk);
        glitch_clr = 1'b0;
    endtask
`endif

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vec_t vecs[12];
        logic early;
        int   len;
        logic v;

        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n      = 1'b0;
        glitch_clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_dout_def", dout_def, 1'b0);
        checkOutput("reset_busy_def", busy_def, 1'b0);
        checkOutput("reset_dout1", dout1, 1'b0);
        checkOutput("reset_busy1", busy1, 1'b0);
        checkOutput("reset_dout8", dout8, 1'b0);
        checkOutput("reset_busy8", busy8, 1'b0);
        model_en = 1'b1;

        $display("[TB] default latency");
        applyStimulus(1'b1, 1'b0, 1'b0);
        early = 1'b0;
        for (int e = 1; e <= 1002; e++) begin
            @(negedge clk);
            if (e < 1002 && dout_def === 1'b1) early = 1'b1;
            if (e == 2)    checkOutput("def_busy_e2", busy_def, 1'b0);
            if (e == 3)    checkOutput("def_busy_e3", busy_def, 1'b1);
            if (e == 1001) checkOutput("def_busy_e1001", busy_def, 1'b1);
            if (e == 1001) checkOutput("def_dout_e1001", dout_def, 1'b0);
            if (e == 1002) checkOutput("def_dout_e1002", dout_def, 1'b1);
            if (e == 1002) checkOutput("def_busy_e1002", busy_def, 1'b0);
        end
        checkOutput("def_no_early_dout", early, 1'b0);

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(din_def, vecs[i].din1, vecs[i].din8);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_dout1", i), dout1, vecs[i].exp_dout1);
            checkOutput($sformatf("vec%0d_busy1", i), busy1, vecs[i].exp_busy1);
            checkOutput($sformatf("vec%0d_dout8", i), dout8, vecs[i].exp_dout8);
            checkOutput($sformatf("vec%0d_busy8", i), busy8, vecs[i].exp_busy8);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        checkOutput("pulse_glitch_cnt", gcnt8, 8'd1);
`endif

        $display("[TB] toggle then hold");
        for (int c = 0; c < 60; c++) begin
            applyStimulus(din_def, din1, ((c / 3) % 2 == 0));
            @(negedge clk);
            checkOutput("toggle_dout8", dout8, 1'b0);
        end
        applyStimulus(din_def, din1, 1'b1);
        for (int e = 61; e <= 70; e++) begin
            @(negedge clk);
            if (e == 69) checkOutput("hold_dout8_e69", dout8, 1'b0);
            if (e == 70) checkOutput("hold_dout8_e70", dout8, 1'b1);
        end

        $display("[TB] reset during confirm");
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("confirm_busy8", busy8, 1'b1);
        checkOutput("confirm_dout8", dout8, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort_dout8", dout8, 1'b0);
        checkOutput("abort_busy8", busy8, 1'b0);
        checkOutput("abort_dout_def", dout_def, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("after_abort_dout8", dout8, 1'b0);
        checkOutput("after_abort_busy8", busy8, 1'b0);
        checkOutput("after_abort_busy_def", busy_def, 1'b0);

        $display("[TB] random run");
        for (int seg = 0; seg < 150; seg++) begin
            v   = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                applyStimulus(1'b0, logic'($urandom_range(0, 1)), v);
                rst_n      = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
                glitch_clr = ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0;
                @(negedge clk);
            end
        end
        rst_n      = 1'b1;
        glitch_clr = 1'b0;

`ifdef DEBOUNCE_GLITCH_CNT_EN
        $display("[TB] glitch counter");
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 300; g++) glitchPulse(1'b0);
        checkOutput("glitch_saturated", gcnt8, 8'd255);
        checkOutput("glitch_dout8", dout8, 1'b0);
        glitchPulse(1'b1);
        checkOutput("glitch_clr_wins_sat", gcnt8, 8'd0);
        glitchPulse(1'b0);
        checkOutput("glitch_after_clr", gcnt8, 8'd1);
        glitchPulse(1'b1);
        checkOutput("glitch_clr_wins", gcnt8, 8'd0);
        checkOutput("glitch_cnt1", gcnt1, 8'd0);
        checkOutput("glitch_cnt_def", gcnt_def, 8'd0);
`endif

        @(negedge clk);
        model_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
